// File: rtl/dec_entry2.sv
// Two-digit BCD entry: debounced enter key loads tens then units, registers BIN = DEZ*10+UNI.
// Latency: key edge to outputs DEB_CYCLES+2 cycles (clear: 3 cycles); no backpressure, operator-paced.
module dec_entry2 #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       KEY_ENT,
  input  logic       KEY_CLR,
  output logic [3:0] DEZ,
  output logic [3:0] UNI,
  output logic [6:0] BIN,
  output logic       VALID,
  output logic       ERR,
  output logic       WAIT_UNI
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] FLIP_AT = CW'((DEB_CYCLES > 1) ? DEB_CYCLES - 2 : 0);
  localparam logic [CW-1:0] ARM_AT  = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TENS, DONE} state_t;

  logic          ent_s1, ent_s2, clr_s1, clr_s2;
  logic          ent_deb, ent_deb_d;
  logic [CW-1:0] deb_cnt;
  logic          armed;
  logic [CW-1:0] arm_cnt;
  logic          ent_stb;

  state_t        state, state_n;
  logic [3:0]    dez_n, uni_n;
  logic [6:0]    bin_n, dez_x10;
  logic          valid_n, err_n, wait_uni_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent_s1 <= 1'b1;
      ent_s2 <= 1'b1;
      clr_s1 <= 1'b1;
      clr_s2 <= 1'b1;
    end else begin
      ent_s1 <= KEY_ENT;
      ent_s2 <= ent_s1;
      clr_s1 <= KEY_CLR;
      clr_s2 <= clr_s1;
    end
  end

  // Level flips on the edge the run of differing samples would bring the count to DEB_CYCLES-1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ent_deb   <= 1'b1;
      ent_deb_d <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      ent_deb_d <= ent_deb;
      if (ent_s2 != ent_deb) begin
        if (deb_cnt == FLIP_AT) begin
          ent_deb <= ent_s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // A key held through reset must first be seen stably released before presses count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (ent_s2 && ent_deb) begin
        if (arm_cnt == ARM_AT) armed <= 1'b1;
        else                   arm_cnt <= arm_cnt + CW'(1);
      end else begin
        arm_cnt <= '0;
      end
    end
  end

  assign ent_stb = armed & ent_deb_d & ~ent_deb;
  assign dez_x10 = ({3'b000, DEZ} << 3) + ({3'b000, DEZ} << 1);

  always_comb begin
    state_n = state;
    dez_n   = DEZ;
    uni_n   = UNI;
    bin_n   = BIN;
    valid_n = VALID;
    err_n   = 1'b0;
    if (!clr_s2) begin
      state_n = IDLE;
      dez_n   = 4'd0;
      uni_n   = 4'd0;
      bin_n   = 7'd0;
      valid_n = 1'b0;
    end else if (ent_stb) begin
      if (SW > 4'd9) begin
        err_n = 1'b1;
      end else begin
        case (state)
          TENS: begin
            uni_n   = SW;
            bin_n   = dez_x10 + {3'b000, SW};
            valid_n = 1'b1;
            state_n = DONE;
          end
          default: begin
            dez_n   = SW;
            uni_n   = 4'd0;
            bin_n   = 7'd0;
            valid_n = 1'b0;
            state_n = TENS;
          end
        endcase
      end
    end
    wait_uni_n = (state_n == TENS);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      DEZ      <= 4'd0;
      UNI      <= 4'd0;
      BIN      <= 7'd0;
      VALID    <= 1'b0;
      ERR      <= 1'b0;
      WAIT_UNI <= 1'b0;
    end else begin
      state    <= state_n;
      DEZ      <= dez_n;
      UNI      <= uni_n;
      BIN      <= bin_n;
      VALID    <= valid_n;
      ERR      <= err_n;
      WAIT_UNI <= wait_uni_n;
    end
  end

endmodule

// File: tb/tb_dec_entry2.sv
// Directed bench for dec_entry2 with DEB_CYCLES=4 and hand-computed expectations.
module tb_dec_entry2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] SW;
  logic       KEY_ENT;
  logic       KEY_CLR;
  logic [3:0] DEZ;
  logic [3:0] UNI;
  logic [6:0] BIN;
  logic       VALID;
  logic       ERR;
  logic       WAIT_UNI;

  int vectors = 0;
  int miscompares = 0;

  dec_entry2 #(.DEB_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY_ENT(KEY_ENT), .KEY_CLR(KEY_CLR),
    .DEZ(DEZ), .UNI(UNI), .BIN(BIN), .VALID(VALID), .ERR(ERR), .WAIT_UNI(WAIT_UNI)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    SW = d;
    KEY_ENT = 1'b0;
    tick(12);
    KEY_ENT = 1'b1;
    tick(12);
  endtask

  initial begin
    RST_N = 1'b1; SW = 4'd0; KEY_ENT = 1'b1; KEY_CLR = 1'b1;
    #2 RST_N = 1'b0;
    tick(2);
    chk("rst_dez", {4'd0, DEZ}, 8'd0);
    chk("rst_uni", {4'd0, UNI}, 8'd0);
    chk("rst_bin", {1'b0, BIN}, 8'd0);
    chk("rst_valid", {7'd0, VALID}, 8'd0);
    chk("rst_err", {7'd0, ERR}, 8'd0);
    chk("rst_wait", {7'd0, WAIT_UNI}, 8'd0);
    RST_N = 1'b1;
    tick(10);

    // Exact latency: key low after edge 0, registers load at edge 6.
    SW = 4'd4; KEY_ENT = 1'b0;
    tick(5);
    chk("lat_dez_early", {4'd0, DEZ}, 8'd0);
    chk("lat_wait_early", {7'd0, WAIT_UNI}, 8'd0);
    tick(1);
    chk("lat_dez", {4'd0, DEZ}, 8'd4);
    chk("lat_wait", {7'd0, WAIT_UNI}, 8'd1);
    chk("lat_valid", {7'd0, VALID}, 8'd0);
    KEY_ENT = 1'b1;
    tick(12);
    chk("rel_dez", {4'd0, DEZ}, 8'd4);

    press(4'd7);
    chk("e47_dez", {4'd0, DEZ}, 8'd4);
    chk("e47_uni", {4'd0, UNI}, 8'd7);
    chk("e47_bin", {1'b0, BIN}, 8'd47);
    chk("e47_valid", {7'd0, VALID}, 8'd1);
    chk("e47_wait", {7'd0, WAIT_UNI}, 8'd0);

    press(4'd9);
    chk("new_valid", {7'd0, VALID}, 8'd0);
    chk("new_dez", {4'd0, DEZ}, 8'd9);
    chk("new_bin", {1'b0, BIN}, 8'd0);
    chk("new_wait", {7'd0, WAIT_UNI}, 8'd1);
    press(4'd9);
    chk("e99_bin", {1'b0, BIN}, 8'd99);
    chk("e99_uni", {4'd0, UNI}, 8'd9);
    chk("e99_valid", {7'd0, VALID}, 8'd1);

    // Clear latency: low after edge 0, cleared at edge 3.
    KEY_CLR = 1'b0;
    tick(2);
    chk("clr_early", {7'd0, VALID}, 8'd1);
    tick(1);
    chk("clr_valid", {7'd0, VALID}, 8'd0);
    chk("clr_bin", {1'b0, BIN}, 8'd0);
    chk("clr_dez", {4'd0, DEZ}, 8'd0);
    KEY_CLR = 1'b1;
    tick(4);

    SW = 4'd12; KEY_ENT = 1'b0;
    tick(5);
    chk("err_early", {7'd0, ERR}, 8'd0);
    tick(1);
    chk("err_idle", {7'd0, ERR}, 8'd1);
    tick(1);
    chk("err_pulse", {7'd0, ERR}, 8'd0);
    chk("err_idle_dez", {4'd0, DEZ}, 8'd0);
    chk("err_idle_wait", {7'd0, WAIT_UNI}, 8'd0);
    KEY_ENT = 1'b1;
    tick(12);

    press(4'd3);
    SW = 4'd12; KEY_ENT = 1'b0;
    tick(6);
    chk("err_tens", {7'd0, ERR}, 8'd1);
    chk("err_tens_wait", {7'd0, WAIT_UNI}, 8'd1);
    chk("err_tens_dez", {4'd0, DEZ}, 8'd3);
    tick(1);
    chk("err_tens_pulse", {7'd0, ERR}, 8'd0);
    KEY_ENT = 1'b1;
    tick(12);

    KEY_CLR = 1'b0; tick(5); KEY_CLR = 1'b1; tick(4);
    SW = 4'd5;
    for (int i = 0; i < 10; i++) begin
      KEY_ENT = ~KEY_ENT;
      tick(2);
    end
    KEY_ENT = 1'b0;
    chk("bounce_none", {4'd0, DEZ}, 8'd0);
    tick(12);
    chk("bounce_dez", {4'd0, DEZ}, 8'd5);
    chk("bounce_uni", {4'd0, UNI}, 8'd0);
    chk("bounce_wait", {7'd0, WAIT_UNI}, 8'd1);
    KEY_ENT = 1'b1;
    tick(12);

    // Clear and enter together while in TENS: clear must win.
    SW = 4'd6; KEY_CLR = 1'b0; KEY_ENT = 1'b0;
    tick(10);
    chk("ce_dez", {4'd0, DEZ}, 8'd0);
    chk("ce_uni", {4'd0, UNI}, 8'd0);
    chk("ce_wait", {7'd0, WAIT_UNI}, 8'd0);
    chk("ce_err", {7'd0, ERR}, 8'd0);
    KEY_CLR = 1'b1;
    tick(6);
    chk("ce_after_dez", {4'd0, DEZ}, 8'd0);
    chk("ce_after_wait", {7'd0, WAIT_UNI}, 8'd0);
    KEY_ENT = 1'b1;
    tick(12);

    press(4'd2);
    SW = 4'd8; KEY_ENT = 1'b0;
    tick(3);
    RST_N = 1'b0;
    #2;
    chk("arst_dez", {4'd0, DEZ}, 8'd0);
    chk("arst_wait", {7'd0, WAIT_UNI}, 8'd0);
    tick(2);
    RST_N = 1'b1;
    tick(20);
    chk("held_dez", {4'd0, DEZ}, 8'd0);
    chk("held_wait", {7'd0, WAIT_UNI}, 8'd0);
    KEY_ENT = 1'b1;
    tick(20);
    chk("rel_dez2", {4'd0, DEZ}, 8'd0);
    press(4'd8);
    chk("repress_dez", {4'd0, DEZ}, 8'd8);
    chk("repress_wait", {7'd0, WAIT_UNI}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
